// File: rtl/bell_pkg.sv
// Shared types and default timing constants for the bell buzzer driver.
package bell_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_MUTED} state_t;

  localparam int CLK_HZ        = 50000000;
  localparam int DEF_TONE_HALF = CLK_HZ / 4000;  // 2 kHz tone
  localparam int DEF_ON        = CLK_HZ / 10;    // 100 ms beep
  localparam int DEF_OFF       = CLK_HZ / 10;    // 100 ms pause
endpackage

// File: rtl/tone_div.sv
// Restartable half-period divider: a registered square wave that starts high on restart.
// The output is held low whenever the divider is neither restarted nor running.
module tone_div #(
  parameter int W = 14
) (
  input  logic         clk_50M,
  input  logic         rst,
  input  logic         restart,
  input  logic         run,
  input  logic [W-1:0] half_cyc,
  output logic         wave
);
  logic [W-1:0] r_cnt;
  logic         r_wave;

  always_ff @(posedge clk_50M) begin
    if (rst || !(restart || run)) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_wave <= 1'b1;
    end else if (r_cnt == half_cyc - W'(1)) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + W'(1);
    end
  end

  assign wave = r_wave;
endmodule

// File: rtl/bell_buzzer_drv.sv
// Bell level to piezo drive: tone gated into a beep/pause cadence with mute and beep count.
// Define ALT_TONE_EN for a two-tone chime (even-numbered beeps use TONE2_HALF_CYC).
module bell_buzzer_drv import bell_pkg::*; #(
  parameter int TONE_HALF_CYC  = DEF_TONE_HALF,
  parameter int ON_CYC         = DEF_ON,
  parameter int OFF_CYC        = DEF_OFF
`ifdef ALT_TONE_EN
  ,parameter int TONE2_HALF_CYC = 8333
`endif
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       bell_in,
  input  logic       mute,
  output logic       buzzer_out,
  output logic       ringing,
  output logic [7:0] beep_cnt
);
  localparam int W_ON  = $clog2(ON_CYC + 1);
  localparam int W_OFF = $clog2(OFF_CYC + 1);
`ifdef ALT_TONE_EN
  localparam int W_TONE = $clog2(((TONE_HALF_CYC > TONE2_HALF_CYC) ?
                                  TONE_HALF_CYC : TONE2_HALF_CYC) + 1);
`else
  localparam int W_TONE = $clog2(TONE_HALF_CYC + 1);
`endif

  state_t           r_state, w_nxt;
  logic [W_ON-1:0]  r_on_cnt;
  logic [W_OFF-1:0] r_off_cnt;
  logic [7:0]       r_beep_cnt, w_beep_nxt;
  logic             r_ringing, w_ring_nxt;
  logic             w_enter_on, w_run_on, w_run_off;
  logic             w_on_tc, w_off_tc;
  logic [W_TONE-1:0] w_half;

  assign w_on_tc  = (r_on_cnt  == W_ON'(ON_CYC - 1));
  assign w_off_tc = (r_off_cnt == W_OFF'(OFF_CYC - 1));

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_on_cnt   <= '0;
      r_off_cnt  <= '0;
      r_beep_cnt <= '0;
      r_ringing  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_on_cnt   <= w_run_on  ? r_on_cnt  + W_ON'(1)  : '0;
      r_off_cnt  <= w_run_off ? r_off_cnt + W_OFF'(1) : '0;
      r_beep_cnt <= w_beep_nxt;
      r_ringing  <= w_ring_nxt;
    end
  end

  // Mute outranks both cadence terminals; bell_in is only looked at at the end of a pause.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bell_in) w_nxt = mute ? ST_MUTED : ST_ON;
      ST_ON:    if (mute) w_nxt = ST_MUTED;
                else if (w_on_tc) w_nxt = ST_OFF;
      ST_OFF:   if (mute) w_nxt = ST_MUTED;
                else if (w_off_tc) w_nxt = bell_in ? ST_ON : ST_IDLE;
      ST_MUTED: if (!bell_in) w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_enter_on = (w_nxt == ST_ON) && (r_state != ST_ON);
    w_run_on   = (w_nxt == ST_ON) && (r_state == ST_ON);
    w_run_off  = (w_nxt == ST_OFF) && (r_state == ST_OFF);
    w_ring_nxt = (w_nxt == ST_ON) || (w_nxt == ST_OFF);
    w_beep_nxt = r_beep_cnt;
    if (w_enter_on)
      w_beep_nxt = (r_state == ST_IDLE) ? 8'd1 :
                   (r_beep_cnt == 8'hFF) ? 8'hFF : r_beep_cnt + 8'd1;
  end

`ifdef ALT_TONE_EN
  logic [W_TONE-1:0] r_half;
  always_ff @(posedge clk_50M) begin
    if (rst)
      r_half <= W_TONE'(TONE_HALF_CYC);
    else if (w_enter_on)
      r_half <= w_beep_nxt[0] ? W_TONE'(TONE_HALF_CYC) : W_TONE'(TONE2_HALF_CYC);
  end
  assign w_half = r_half;
`else
  assign w_half = W_TONE'(TONE_HALF_CYC);
`endif

  tone_div #(.W(W_TONE)) u_tone (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .restart  (w_enter_on),
    .run      (w_run_on),
    .half_cyc (w_half),
    .wave     (buzzer_out)
  );

  assign ringing  = r_ringing;
  assign beep_cnt = r_beep_cnt;
endmodule

// File: doc/bell_buzzer_drv.md
Name: bell_buzzer_drv

Overview:
- Downstream stage of the alarm/chime bell logic. Consumes its level output (bell asserted while the alarm matches or the hourly chime window is open).
- Converts that level into an audible drive for a piezo buzzer pin:
  - square-wave tone,
  - gated into a beep/pause cadence.
- Also supports user mute and reports a beep count to the display/status logic.

Parameters:
- TONE_HALF_CYC, 12500, clk_50M cycles per tone half-period (2 kHz at 50 MHz); legal range >=1.
- ON_CYC, 5000000, cycles per beep (100 ms); legal range >=1.
- OFF_CYC, 5000000, cycles per pause between beeps (100 ms); legal range >=1.
- TONE2_HALF_CYC, 8333, half-period of the alternate tone (3 kHz); used only with ALT_TONE_EN.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- bell_in  in  1  bell request level from the alarm/chime compare stage; same clock domain, no synchroniser.
- mute  in  1  level or pulse; silences the current ringing episode.
- buzzer_out  out  1  registered tone drive to the buzzer pin.
- ringing  out  1  registered; high in states ON and OFF.
- beep_cnt  out  8  registered; number of beeps started in the current episode, saturating at 255.

Behaviour:
- States: IDLE, ON, OFF, MUTED. All outputs are registered.
- Reset (also when asserted mid-operation), effective at the next edge:
  - state=IDLE, buzzer_out=0, ringing=0, beep_cnt=0, all counters 0.
- IDLE:
  - bell_in=1 and mute=0 -> ON at the next edge: buzzer_out<=1, tone_cnt<=0, on_cnt<=0, beep_cnt<=1.
  - bell_in=1 and mute=1 -> MUTED.
  - Otherwise stay in IDLE; buzzer_out=0.
- ON:
  - tone_cnt counts 0..TONE_HALF_CYC-1. At the terminal count, buzzer_out toggles and tone_cnt wraps to 0.
  - on_cnt counts 0..ON_CYC-1. At the terminal count -> OFF: buzzer_out<=0, off_cnt<=0.
  - Net effect: the ON state lasts exactly ON_CYC cycles.
- OFF:
  - buzzer_out held at 0. off_cnt counts 0..OFF_CYC-1.
  - At the terminal count: if bell_in=1 -> ON (same entry actions as from IDLE, except beep_cnt<=beep_cnt+1, saturating at 255). Otherwise -> IDLE.
- bell_in falling during ON or OFF:
  - The current beep and pause run to completion; no truncated chirp. Then -> IDLE.
- mute=1 in ON or OFF:
  - MUTED at the next edge, buzzer_out<=0.
  - Mute has priority over counter terminals; only rst has higher priority.
- MUTED:
  - buzzer_out=0, ringing=0.
  - Stays in MUTED while bell_in=1, regardless of mute.
  - bell_in=0 -> IDLE at the next edge.
  - A new episode therefore requires bell_in to drop and rise again.
- beep_cnt holds its value in IDLE and MUTED until the next IDLE->ON transition.
- Counter widths: $clog2(param+1), with no overflow. Comparisons use the full parameter value.

Optional Feature:
- Macro ALT_TONE_EN.
- Defined:
  - Odd-numbered beeps (beep_cnt LSB=1) use TONE_HALF_CYC; even-numbered beeps use TONE2_HALF_CYC.
  - The half-period is latched on ON entry and is constant within a beep.
  - Gives a two-tone chime.
- Undefined: every beep uses TONE_HALF_CYC; TONE2_HALF_CYC is unused and no extra logic is inferred.

Decomposition:
- Package bell_pkg:
  - state enum (IDLE, ON, OFF, MUTED);
  - default cycle constants CLK_HZ=50000000, DEF_TONE_HALF, DEF_ON, DEF_OFF.
- Sub-module tone_div: restartable half-period divider.
  - Inputs: clk_50M, rst, restart, half_cyc.
  - Output: registered square wave, starting high on restart.
  - Instantiated once; the FSM and cadence counters stay in the top.

Test Plan:
- Bench parameters throughout: TONE_HALF_CYC=4, ON_CYC=20, OFF_CYC=10.
1. Basic beep: raise bell_in, then:
   - buzzer_out=1 one cycle later;
   - buzzer_out toggles every 4 cycles (pattern 1111 0000 1111 0000 1111);
   - forced 0 after 20 cycles, 0 for 10 cycles, second beep starts;
   - ringing=1 throughout; beep_cnt 1 then 2.
2. Release mid-beep: drop bell_in at cycle 7 of the first ON -> the ON completes (20 cycles) and OFF completes (10 cycles) -> IDLE; beep_cnt stays 1; no third edge activity.
3. Mute: pulse mute at cycle 5 of beep 3 while bell_in stays high -> buzzer_out=0 next cycle, ringing=0, held for 200 cycles; drop bell_in -> IDLE; re-raise -> new beep with beep_cnt=1.
4. Reset mid-ON: assert rst for 1 cycle at ON cycle 9 -> all outputs 0 next edge; with bell_in still high, ON re-entered the cycle after rst deasserts.
5. Saturation: hold bell_in for 300 beeps -> beep_cnt reaches 255 and holds; cadence unchanged.
6. ALT_TONE_EN build with TONE2_HALF_CYC=2 -> beep 1 toggles every 4 cycles, beep 2 every 2 cycles, beep 3 every 4 cycles.
